lif_neuron_ctrl: RTL and testbench



---
 rtl/lif_neuron_ctrl.sv | 138 +++++++++++++
 tb/tb_lif_neuron_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_ctrl.sv
// Leaky integrate-and-fire update controller: owns the membrane potential register,
// integrates handshaked synaptic currents with leak and saturation, and emits spikes.
module lif_neuron_ctrl #(
  parameter int WIDTH      = 12,
  parameter int V_REST     = 0,
  parameter int V_RESET    = 0,
  parameter int V_TH       = 256,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACT    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_current,
  output logic                    in_ready,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic signed [WIDTH-1:0] v_mem,
  output logic                    refractory,
  output logic [1:0]              state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid is held by the producer until that edge and the payload is sampled only there.

  localparam int SW = WIDTH + 2;
  localparam int CW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

  localparam logic signed [WIDTH-1:0] V_REST_W  = WIDTH'(V_REST);
  localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);
  localparam logic signed [WIDTH-1:0] V_TH_W    = WIDTH'(V_TH);
  localparam logic signed [SW-1:0]    S_MAX     = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]    S_MIN     = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UPDATE  = 2'd1,
    S_FIRE    = 2'd2,
    S_REFRACT = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  v_q, v_d;
  logic signed [WIDTH-1:0]  cur_q, cur_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  logic signed [WIDTH-1:0]  leak;
  logic signed [SW-1:0]     sum;
  logic signed [WIDTH-1:0]  sat;
  logic                     fire;

  always_comb begin
    leak = v_q >>> LEAK_SHIFT;
    // All three operands are sign-extended to SW bits so the sum cannot wrap.
    sum  = {{2{v_q[WIDTH-1]}}, v_q} - {{2{leak[WIDTH-1]}}, leak}
         + {{2{cur_q[WIDTH-1]}}, cur_q};
    if (sum > S_MAX) begin
      sat = S_MAX[WIDTH-1:0];
    end else if (sum < S_MIN) begin
      sat = S_MIN[WIDTH-1:0];
    end else begin
      sat = sum[WIDTH-1:0];
    end
    fire = (sat >= V_TH_W);
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cur_d   = in_current;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (fire) begin
          v_d     = V_RESET_W;
          state_d = S_FIRE;
        end else begin
          v_d     = sat;
          state_d = S_IDLE;
        end
      end
      S_FIRE: begin
        if (spike_ready) begin
          if (REFRACT > 0) begin
            state_d = S_REFRACT;
            cnt_d   = CW'(REFRACT - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_REFRACT: begin
        // Inputs accepted here are intentionally dropped; v_mem is untouched.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      v_d     = V_REST_W;
      cur_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      v_q     <= V_REST_W;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are pure decodes of the state flop; in_ready is also gated by reset.
  assign in_ready    = rst && ((state_q == S_IDLE) || (state_q == S_REFRACT));
  assign spike_valid = (state_q == S_FIRE);
  assign refractory  = (state_q == S_REFRACT);
  assign v_mem       = v_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_lif_neuron_ctrl.sv
// Self-checking bench for lif_neuron_ctrl: directed scenarios plus randomized currents
// compared against an integer-arithmetic model of the neuron.
module tb_lif_neuron_ctrl;

  localparam int W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear;

  logic                a_in_valid, a_in_ready, a_spike_valid, a_spike_ready, a_refractory;
  logic signed [W-1:0] a_in_current, a_v_mem;
  logic [1:0]          a_state;

  logic                h_in_valid, h_in_ready, h_spike_valid, h_spike_ready, h_refractory;
  logic signed [W-1:0] h_in_current, h_v_mem;
  logic [1:0]          h_state;

  int checks = 0;
  int errors = 0;
  int mv;
  logic [W-1:0] exp_q[$];

  lif_neuron_ctrl dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(a_in_valid), .in_current(a_in_current), .in_ready(a_in_ready),
    .spike_valid(a_spike_valid), .spike_ready(a_spike_ready),
    .v_mem(a_v_mem), .refractory(a_refractory), .state_dbg(a_state)
  );

  lif_neuron_ctrl #(.V_TH(2047)) dut_hi (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(h_in_valid), .in_current(h_in_current), .in_ready(h_in_ready),
    .spike_valid(h_spike_valid), .spike_ready(h_spike_ready),
    .v_mem(h_v_mem), .refractory(h_refractory), .state_dbg(h_state)
  );

  // Neuron rule in plain integers: floor-division leak, clamp, threshold.
  function automatic int model_next(input int v, input int cur, input int vth, output bit fire);
    int leak, s;
    if (v >= 0) leak = v / 16;
    else        leak = -((-v + 15) / 16);
    s = v - leak + cur;
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
    fire = (s >= vth);
    return fire ? 0 : s;
  endfunction

  task automatic send_a(input int cur);
    int budget;
    budget = 20;
    while (!a_in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_a_ready: in_ready=%0b required 1", a_in_ready);
    end
    a_in_valid = 1'b1;
    a_in_current = W'(cur);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL update_ready: in_ready=%0b required 0", a_in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_h(input int cur);
    int budget;
    budget = 20;
    while (!h_in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checks++;
    if (h_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_h_ready: in_ready=%0b required 1", h_in_ready);
    end
    h_in_valid = 1'b1;
    h_in_current = W'(cur);
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mv = 0;
  endtask

  // Holds the spike for `hold` cycles, completes the handshake, then walks the
  // refractory window offering random inputs; reports the window length.
  task automatic spike_and_refract_a(input int hold, output int rcount);
    a_spike_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (a_spike_valid !== 1'b1 || a_v_mem !== 0) begin
        errors++;
        $display("FAIL spike_hold: spike_valid=%0b v_mem=%0d required 1 and 0", a_spike_valid, a_v_mem);
      end
    end
    a_spike_ready = 1'b1;
    @(posedge clk); #1;
    a_spike_ready = 1'b0;
    rcount = 0;
    for (int i = 0; i < 12 && a_refractory; i++) begin
      checks++;
      if (a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL refract_ready: in_ready=%0b required 1", a_in_ready);
      end
      a_in_valid = 1'b1;
      a_in_current = W'($urandom_range(0, 1000));
      rcount++;
      @(posedge clk); #1;
      checks++;
      if (a_v_mem !== 0) begin
        errors++;
        $display("FAIL refract_vmem: v_mem=%0d required 0", a_v_mem);
      end
    end
    a_in_valid = 1'b0;
    checks++;
    if (rcount != 4) begin
      errors++;
      $display("FAIL refract_len: cycles=%0d required 4", rcount);
    end
    checks++;
    if (a_in_ready !== 1'b1 || a_spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL refract_exit: in_ready=%0b spike_valid=%0b required 1 and 0", a_in_ready, a_spike_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0;
    a_in_valid = 1'b0; a_in_current = '0; a_spike_ready = 1'b0;
    h_in_valid = 1'b0; h_in_current = '0; h_spike_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_v_mem !== 0 || a_spike_valid !== 1'b0 || a_in_ready !== 1'b0 || a_refractory !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v_mem=%0d spike_valid=%0b in_ready=%0b refractory=%0b required 0 0 0 0",
               a_v_mem, a_spike_valid, a_in_ready, a_refractory);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: in_ready=%0b required 1", a_in_ready);
    end
    mv = 0;
  endtask

  task automatic test_integration();
    int spec_v[2];
    int vexp;
    bit f;
    spec_v = '{100, 194};
    for (int i = 0; i < 2; i++) begin
      vexp = model_next(mv, 100, 256, f);
      send_a(100);
      checks++;
      if (a_v_mem !== W'(spec_v[i]) || a_spike_valid !== 1'(f)) begin
        errors++;
        $display("FAIL integrate_%0d: v_mem=%0d spike=%0b required %0d %0b", i, a_v_mem, a_spike_valid, spec_v[i], f);
      end
      mv = vexp;
    end
  endtask

  task automatic test_firing();
    send_a(100);
    checks++;
    if (a_v_mem !== 0 || a_spike_valid !== 1'b1 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fire: v_mem=%0d spike_valid=%0b in_ready=%0b required 0 1 0", a_v_mem, a_spike_valid, a_in_ready);
    end
    mv = 0;
  endtask

  task automatic test_backpressure();
    int rc;
    spike_and_refract_a(3, rc);
    @(posedge clk); #1;
    checks++;
    if (a_v_mem !== 0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_refract: v_mem=%0d in_ready=%0b required 0 1", a_v_mem, a_in_ready);
    end
  endtask

  task automatic test_neg_leak();
    send_a(-5);
    checks++;
    if (a_v_mem !== -12'sd5) begin
      errors++;
      $display("FAIL neg_input: v_mem=%0d required -5", a_v_mem);
    end
    send_a(0);
    checks++;
    if (a_v_mem !== -12'sd4) begin
      errors++;
      $display("FAIL neg_leak: v_mem=%0d required -4", a_v_mem);
    end
    mv = -4;
  endtask

  task automatic test_saturation();
    int hb;
    pulse_clear();
    for (int i = 0; i < 2; i++) begin
      send_a(-2048);
      checks++;
      if (a_v_mem !== -12'sd2048 || a_spike_valid !== 1'b0) begin
        errors++;
        $display("FAIL sat_neg_%0d: v_mem=%0d spike=%0b required -2048 0", i, a_v_mem, a_spike_valid);
      end
    end
    mv = -2048;
    send_h(2000);
    checks++;
    if (h_v_mem !== 12'sd2000 || h_spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_hi_pre: v_mem=%0d spike=%0b required 2000 0", h_v_mem, h_spike_valid);
    end
    send_h(2047);
    checks++;
    if (h_v_mem !== 0 || h_spike_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos_fire: v_mem=%0d spike=%0b required 0 1", h_v_mem, h_spike_valid);
    end
    h_spike_ready = 1'b1;
    @(posedge clk); #1;
    h_spike_ready = 1'b0;
    hb = 0;
    while (h_refractory && hb < 12) begin
      @(posedge clk); #1;
      hb++;
    end
    checks++;
    if (h_in_ready !== 1'b1 || h_refractory !== 1'b0) begin
      errors++;
      $display("FAIL sat_hi_idle: in_ready=%0b refractory=%0b required 1 0", h_in_ready, h_refractory);
    end
  endtask

  task automatic test_random();
    int cur, vexp, rc;
    bit f;
    logic [W-1:0] e;
    pulse_clear();
    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 4) cur = int'($urandom_range(0, 4095)) - 2048;
      else            cur = int'($urandom_range(0, 1200)) - 600;
      vexp = model_next(mv, cur, 256, f);
      exp_q.push_back(W'(vexp));
      send_a(cur);
      e = exp_q.pop_front();
      checks++;
      if (a_v_mem !== e || a_spike_valid !== 1'(f)) begin
        errors++;
        $display("FAIL random_%0d: cur=%0d v_mem=%0d spike=%0b required %0d %0b",
                 n, cur, a_v_mem, a_spike_valid, $signed(e), f);
      end
      mv = vexp;
      if (f) spike_and_refract_a(int'($urandom_range(0, 3)), rc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    pulse_clear();
    send_a(50);
    checks++;
    if (a_v_mem !== 12'sd50) begin
      errors++;
      $display("FAIL pre_reset: v_mem=%0d required 50", a_v_mem);
    end
    a_in_valid = 1'b1;
    a_in_current = 12'sd70;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (a_v_mem !== 0 || a_spike_valid !== 1'b0 || a_in_ready !== 1'b0 || a_refractory !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: v_mem=%0d spike=%0b in_ready=%0b refr=%0b required 0 0 0 0",
               a_v_mem, a_spike_valid, a_in_ready, a_refractory);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (a_v_mem !== 0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: v_mem=%0d in_ready=%0b required 0 1", a_v_mem, a_in_ready);
    end
    mv = 0;
  endtask

  task automatic test_clear_fire();
    send_a(300);
    checks++;
    if (a_spike_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: spike_valid=%0b required 1", a_spike_valid);
    end
    a_spike_ready = 1'b0;
    pulse_clear();
    checks++;
    if (a_spike_valid !== 1'b0 || a_refractory !== 1'b0 || a_in_ready !== 1'b1 || a_v_mem !== 0) begin
      errors++;
      $display("FAIL clear_fire: spike=%0b refr=%0b in_ready=%0b v_mem=%0d required 0 0 1 0",
               a_spike_valid, a_refractory, a_in_ready, a_v_mem);
    end
  endtask

  initial begin
    test_reset();
    test_integration();
    test_firing();
    test_backpressure();
    test_neg_leak();
    test_saturation();
    test_random();
    test_async_reset();
    test_clear_fire();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
